// File: rtl/mult_issue_unit_if.sv
// Multiply issue-unit request/response bus and the M-extension op-code package.
// master = issue/writeback side, slave = mult_issue_unit.
package mult_issue_pkg;
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3
  } mult_op_e;
endpackage

interface mult_issue_if #(
  parameter int unsigned TAG_W = 5
);
  import mult_issue_pkg::*;

  logic             req_valid_i;
  logic             req_ready_o;
  mult_op_e         req_op_i;
  logic [31:0]      req_a_i;
  logic [31:0]      req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [31:0]      resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o
  );
endinterface

// File: rtl/mult_issue_unit.sv
// Sequential EX-stage wrapper around the combinational multiplier core (IDLE/CALC/DONE).
// Optional feature macro: MULT_ZERO_BYPASS_EN (zero operand skips CALC, result 0 next cycle).
module multiplier
  import mult_issue_pkg::*;
(
  input  logic        en,
  input  mult_op_e    op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);
  logic        a_sgn;
  logic        b_sgn;
  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // Sign-extend per op; the low 64 bits of the product are then exact for every mix.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op)
      MULH:    begin a_sgn = a[31]; b_sgn = b[31]; end
      MULHSU:  a_sgn = a[31];
      default: ;
    endcase
    a_ext = {{32{a_sgn}}, a};
    b_ext = {{32{b_sgn}}, b};
    res   = en ? (a_ext * b_ext) : '0;
  end
endmodule

module mult_issue_unit
  import mult_issue_pkg::*;
#(
  parameter int unsigned CALC_CYCLES = 2,
  parameter int unsigned TAG_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  mult_issue_if.slave bus,
  output logic        busy_o
);
  localparam int unsigned CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mult_op_e         op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      resp_data_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic             resp_valid_q;
  logic             busy_q;

  logic             ready_c;
  logic             accept_c;
  logic             zero_c;
  logic             core_en_c;
  logic             res_load_c;
  logic             zero_load_c;
  logic [63:0]      core_res;
  logic [31:0]      res_sel_c;

  assign ready_c  = !flush_i & ((state_q == IDLE) | ((state_q == DONE) & bus.resp_ready_i));
  assign accept_c = bus.req_valid_i & ready_c;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_c = (bus.req_a_i == 32'd0) | (bus.req_b_i == 32'd0);
`else
  assign zero_c = 1'b0;
`endif

  // Core sees only latched operands so the request bus may change during CALC.
  multiplier u_core (
    .en  (core_en_c),
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (core_res)
  );

  // Unknown encodings fall through to the low word.
  assign res_sel_c = ((op_q == MULH) || (op_q == MULHSU) || (op_q == MULHU)) ?
                     core_res[63:32] : core_res[31:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_en_c   = 1'b0;
    res_load_c  = 1'b0;
    zero_load_c = 1'b0;
    case (state_q)
      IDLE: ;
      CALC: begin
        core_en_c = 1'b1;
        if (cnt_q == '0) begin
          state_d    = DONE;
          res_load_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: if (bus.resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept_c) begin
      if (zero_c) begin
        state_d     = DONE;
        zero_load_c = 1'b1;
      end else begin
        state_d = CALC;
        cnt_d   = CNT_W'(CALC_CYCLES - 1);
      end
    end
    // Flush beats every handshake; a presented result is dropped.
    if (flush_i) begin
      state_d    = IDLE;
      res_load_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= (state_d == DONE);
      busy_q       <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= MUL;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      if (accept_c) begin
        op_q  <= bus.req_op_i;
        a_q   <= bus.req_a_i;
        b_q   <= bus.req_b_i;
        tag_q <= bus.req_tag_i;
      end
      if (res_load_c) begin
        resp_data_q <= res_sel_c;
        resp_tag_q  <= tag_q;
      end else if (zero_load_c) begin
        resp_data_q <= '0;
        resp_tag_q  <= bus.req_tag_i;
      end
    end
  end

  assign bus.req_ready_o  = ready_c;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_data_o  = resp_data_q;
  assign bus.resp_tag_o   = resp_tag_q;
  assign busy_o           = busy_q;
endmodule

// File: tb/tb_mult_issue_unit.sv
// Directed bench for mult_issue_unit: scoreboard of expected {data, tag} checked at each response.
module tb_mult_issue_unit;
  import mult_issue_pkg::*;

  localparam int unsigned CC = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  int   checks;
  int   errors;
  exp_t sb[$];

  mult_issue_if #(.TAG_W(5)) bus ();

  mult_issue_unit #(.CALC_CYCLES(CC), .TAG_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus     (bus),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input mult_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb_v;
    longint ua;
    longint ub;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua   = longint'({32'd0, a});
    ub   = longint'({32'd0, b});
    case (op)
      MULH:    p = 64'(sa * sb_v);
      MULHSU:  p = 64'(sa * ub);
      default: p = 64'(ua * ub);
    endcase
    if (op == MULH || op == MULHSU || op == MULHU) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_BYPASS_EN
    if (a == 32'd0 || b == 32'd0) return 0;
`endif
    return int'(CC);
  endfunction

  task automatic issue(input mult_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_tag_i   = tag;
    #1;
    check("req_ready_on_issue", 64'(bus.req_ready_o), 64'd1);
    sb.push_back('{exp, tag});
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  // Waits for resp_valid, checks latency, then checks data/tag against the scoreboard head.
  task automatic wait_resp(input string name, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.resp_valid_o && n < int'(CC) + 10) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    if (bus.resp_valid_o && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_data"}, 64'(bus.resp_data_o), 64'(e.data));
      check({name, "_tag"}, 64'(bus.resp_tag_o), 64'(e.tag));
    end else begin
      check({name, "_resp_present"}, 64'(bus.resp_valid_o), 64'd1);
    end
  endtask

  task automatic consume(input string name);
    bus.resp_ready_i = 1'b1;
    tick();
    bus.resp_ready_i = 1'b0;
    check({name, "_valid_after_take"}, 64'(bus.resp_valid_o), 64'd0);
  endtask

  task automatic run_op(input string name, input mult_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    issue(op, a, b, tag, exp);
    wait_resp(name, exp_lat(a, b));
    consume(name);
  endtask

  initial begin
    mult_op_e    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] held_data;
    logic [4:0]  held_tag;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = MUL;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.req_tag_i    = '0;
    bus.resp_ready_i = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rst_resp_data", 64'(bus.resp_data_o), 64'd0);
    check("rst_resp_tag", 64'(bus.resp_tag_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);

    // Sign-rule vectors
    run_op("mulh_m1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
    run_op("mulhu_m1", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF);
    run_op("mul_lo", MUL, 32'h0001_0000, 32'h0001_0003, 5'd4, 32'h0003_0000);
    run_op("unknown_op", mult_op_e'(3'b101), 32'h1234_5678, 32'h0000_0009, 5'd5, 32'hA3D7_0A38);
    run_op("zero_a", MUL, 32'h0000_0000, 32'h0000_1234, 5'd6, 32'h0000_0000);

    // Random operands across all ops
    for (int i = 0; i < 8; i++) begin
      op = mult_op_e'(3'(i % 4));
      a  = $urandom | 32'h1;
      b  = $urandom | 32'h1;
      run_op($sformatf("rand%0d", i), op, a, b, 5'(16 + i), model(op, a, b));
    end

    // Backpressure: result held for 5 stalled cycles
    issue(MULHU, 32'hDEAD_BEEF, 32'h0000_0010, 5'd9, 32'h0000_000D);
    wait_resp("stall", int'(CC));
    held_data = bus.resp_data_o;
    held_tag  = bus.resp_tag_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 64'(bus.resp_valid_o), 64'd1);
      check("stall_data", 64'(bus.resp_data_o), 64'(32'h0000_000D));
      check("stall_tag", 64'(bus.resp_tag_o), 64'(held_tag));
      check("stall_req_ready", 64'(bus.req_ready_o), 64'd0);
    end
    check("stall_data_stable", 64'(bus.resp_data_o), 64'(held_data));

    // Back-to-back: consume and accept on the same edge
    bus.resp_ready_i = 1'b1;
    bus.req_valid_i  = 1'b1;
    bus.req_op_i     = MUL;
    bus.req_a_i      = 32'd3;
    bus.req_b_i      = 32'd5;
    bus.req_tag_i    = 5'd10;
    #1;
    check("b2b_req_ready", 64'(bus.req_ready_o), 64'd1);
    sb.push_back('{32'd15, 5'd10});
    tick();
    bus.resp_ready_i = 1'b0;
    bus.req_valid_i  = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_resp("b2b", int'(CC));
    consume("b2b");

    // Flush in first CALC cycle; a request offered during flush is refused
    issue(MUL, 32'h0000_0042, 32'h0000_0002, 5'd12, 32'h0000_0084);
    flush = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_tag_i   = 5'd20;
    bus.req_a_i     = 32'd1;
    bus.req_b_i     = 32'd1;
    #1;
    check("flush_req_ready", 64'(bus.req_ready_o), 64'd0);
    tick();
    flush = 1'b0;
    bus.req_valid_i = 1'b0;
    void'(sb.pop_back());
    check("flush_busy", 64'(busy), 64'd0);
    for (int i = 0; i < int'(CC) + 2; i++) begin
      check("flush_no_valid", 64'(bus.resp_valid_o), 64'd0);
      tick();
    end
    run_op("after_flush", MUL, 32'h0000_1234, 32'h0000_0010, 5'd7, 32'h0001_2340);

    // Flush while presenting: result dropped despite resp_ready
    issue(MULH, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000);
    wait_resp("flush_done", int'(CC));
    flush = 1'b1;
    bus.resp_ready_i = 1'b1;
    tick();
    flush = 1'b0;
    bus.resp_ready_i = 1'b0;
    check("flush_done_valid", 64'(bus.resp_valid_o), 64'd0);
    check("flush_done_busy", 64'(busy), 64'd0);

    // Reset mid-CALC
    issue(MULHU, 32'h0000_FFFF, 32'h0001_0000, 5'd13, 32'h0000_0000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb.pop_back());
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(bus.resp_valid_o), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("midrst_data", 64'(bus.resp_data_o), 64'd0);
    run_op("after_rst", MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, model(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF));

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
